// File: rtl/lstm_bptt_delta.sv
// LSTM backward-pass delta engine: replays forward gate records newest-first
// and produces per-cell gate and cell-state deltas through one shared datapath.
module lstm_bptt_delta #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24,
    parameter int NUM_LSTM = 8,
    parameter int T_MAX    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_a,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_i,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_f,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_o,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_tc,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_cprev,
    output logic [$clog2(T_MAX):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_ovf,
    input  logic                         i_bwd_start,
    input  logic [NUM_LSTM*WIDTH-1:0]    i_dh,
    input  logic                         i_dh_valid,
    output logic                         o_dh_ready,
    output logic [NUM_LSTM*WIDTH-1:0]    o_d_a,
    output logic [NUM_LSTM*WIDTH-1:0]    o_d_i,
    output logic [NUM_LSTM*WIDTH-1:0]    o_d_f,
    output logic [NUM_LSTM*WIDTH-1:0]    o_d_o,
    output logic [NUM_LSTM*WIDTH-1:0]    o_d_c,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int CW = $clog2(T_MAX) + 1;
    localparam int AW = $clog2(T_MAX);
    localparam int KW = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    typedef logic [NUM_LSTM-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DH,
        S_CELL,
        S_OUT,
        S_DONE
    } state_t;

    function automatic logic [WIDTH-1:0] mul(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{x[WIDTH-1]}}, x})
          * $signed({{WIDTH{y[WIDTH-1]}}, y});
        p = p >>> FRAC;
        return p[WIDTH-1:0];
    endfunction

    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [KW-1:0] k_q, k_d;

    vec_t dh_q, dh_d;
    vec_t wa_q, wa_d, wi_q, wi_d, wf_q, wf_d;
    vec_t wo_q, wo_d, wtc_q, wtc_d, wcp_q, wcp_d;
    vec_t dcn_q, dcn_d, fn_q, fn_d;
    vec_t da_q, da_d, di_q, di_d, df_q, df_d;
    vec_t do_q, do_d, dc_q, dc_d;

    vec_t mem_a   [T_MAX];
    vec_t mem_i   [T_MAX];
    vec_t mem_f   [T_MAX];
    vec_t mem_o   [T_MAX];
    vec_t mem_tc  [T_MAX];
    vec_t mem_cp  [T_MAX];

    logic          full, empty, idle;
    logic          push_en, pop_en, start_en;
    logic [AW-1:0] wr_addr, rd_addr;

    assign full     = (count_q == CW'(T_MAX));
    assign empty    = (count_q == '0);
    assign idle     = (state_q == S_IDLE);
    assign start_en = idle && i_bwd_start;
    assign push_en  = idle && i_push && !i_bwd_start && !full;
    assign pop_en   = (state_q == S_WAIT_DH) && i_dh_valid;
    assign wr_addr  = count_q[AW-1:0];
    assign rd_addr  = AW'(count_q - CW'(1));

    // Record store has no reset: clearing the count is enough to discard it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_a[wr_addr]  <= i_a;
            mem_i[wr_addr]  <= i_i;
            mem_f[wr_addr]  <= i_f;
            mem_o[wr_addr]  <= i_o;
            mem_tc[wr_addr] <= i_tc;
            mem_cp[wr_addr] <= i_cprev;
        end
    end

    logic [WIDTH-1:0] c_dh, c_a, c_i, c_f, c_o, c_tc, c_cp;
    logic [WIDTH-1:0] c_do, c_dc, c_di, c_df, c_da;

    assign c_dh = dh_q[k_q];
    assign c_a  = wa_q[k_q];
    assign c_i  = wi_q[k_q];
    assign c_f  = wf_q[k_q];
    assign c_o  = wo_q[k_q];
    assign c_tc = wtc_q[k_q];
    assign c_cp = wcp_q[k_q];

    assign c_do = mul(mul(mul(c_dh, c_tc), c_o), ONE - c_o);
    assign c_dc = mul(mul(c_dh, c_o), ONE - mul(c_tc, c_tc))
                + mul(dcn_q[k_q], fn_q[k_q]);
    assign c_di = mul(mul(c_dc, c_a), mul(c_i, ONE - c_i));
    assign c_df = mul(mul(c_dc, c_cp), mul(c_f, ONE - c_f));
    assign c_da = mul(c_dc, mul(c_i, ONE - mul(c_a, c_a)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            dh_q    <= '0;
            wa_q    <= '0;
            wi_q    <= '0;
            wf_q    <= '0;
            wo_q    <= '0;
            wtc_q   <= '0;
            wcp_q   <= '0;
            dcn_q   <= '0;
            fn_q    <= '0;
            da_q    <= '0;
            di_q    <= '0;
            df_q    <= '0;
            do_q    <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            dh_q    <= dh_d;
            wa_q    <= wa_d;
            wi_q    <= wi_d;
            wf_q    <= wf_d;
            wo_q    <= wo_d;
            wtc_q   <= wtc_d;
            wcp_q   <= wcp_d;
            dcn_q   <= dcn_d;
            fn_q    <= fn_d;
            da_q    <= da_d;
            di_q    <= di_d;
            df_q    <= df_d;
            do_q    <= do_d;
            dc_q    <= dc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (i_bwd_start)
                    state_d = empty ? S_DONE : S_WAIT_DH;
            S_WAIT_DH:
                if (i_dh_valid)
                    state_d = S_CELL;
            S_CELL:
                if (k_q == KW'(NUM_LSTM - 1))
                    state_d = S_OUT;
            S_OUT:
                state_d = empty ? S_DONE : S_WAIT_DH;
            S_DONE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        dh_d    = dh_q;
        wa_d    = wa_q;
        wi_d    = wi_q;
        wf_d    = wf_q;
        wo_d    = wo_q;
        wtc_d   = wtc_q;
        wcp_d   = wcp_q;
        dcn_d   = dcn_q;
        fn_d    = fn_q;
        da_d    = da_q;
        di_d    = di_q;
        df_d    = df_q;
        do_d    = do_q;
        dc_d    = dc_q;
        if (push_en)
            count_d = count_q + CW'(1);
        if (idle && i_push && !i_bwd_start && full)
            ovf_d = 1'b1;
        if (start_en) begin
            dcn_d = '0;
            fn_d  = '0;
        end
        if (pop_en) begin
            count_d = count_q - CW'(1);
            k_d     = '0;
            dh_d    = i_dh;
            wa_d    = mem_a[rd_addr];
            wi_d    = mem_i[rd_addr];
            wf_d    = mem_f[rd_addr];
            wo_d    = mem_o[rd_addr];
            wtc_d   = mem_tc[rd_addr];
            wcp_d   = mem_cp[rd_addr];
        end
        // Carry d_c and f of this step into the next (older) timestep.
        if (state_q == S_CELL) begin
            k_d        = k_q + KW'(1);
            da_d[k_q]  = c_da;
            di_d[k_q]  = c_di;
            df_d[k_q]  = c_df;
            do_d[k_q]  = c_do;
            dc_d[k_q]  = c_dc;
            dcn_d[k_q] = c_dc;
            fn_d[k_q]  = c_f;
        end
    end

    always_comb begin
        o_dh_ready = 1'b0;
        o_valid    = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        unique case (state_q)
            S_IDLE:    o_busy     = 1'b0;
            S_WAIT_DH: o_dh_ready = 1'b1;
            S_CELL:    o_busy     = 1'b1;
            S_OUT:     o_valid    = 1'b1;
            S_DONE:    o_done     = 1'b1;
            default:   o_busy     = 1'b0;
        endcase
    end

    assign o_count = count_q;
    assign o_full  = full;
    assign o_empty = empty;
    assign o_ovf   = ovf_q;
    assign o_d_a   = da_q;
    assign o_d_i   = di_q;
    assign o_d_f   = df_q;
    assign o_d_o   = do_q;
    assign o_d_c   = dc_q;

endmodule

// File: tb/tb_lstm_bptt_delta.sv
// Directed bench for lstm_bptt_delta with Q16 values, two cells, depth-4 store.
module tb_lstm_bptt_delta;

    localparam int W = 32;
    localparam int N = 2;
    localparam int VW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_push = 1'b0;
    logic [VW-1:0] i_a, i_i, i_f, i_o, i_tc, i_cprev, i_dh;
    logic [2:0] o_count;
    logic o_full, o_empty, o_ovf;
    logic i_bwd_start = 1'b0;
    logic i_dh_valid = 1'b0;
    logic o_dh_ready;
    logic [VW-1:0] o_d_a, o_d_i, o_d_f, o_d_o, o_d_c;
    logic o_valid, o_busy, o_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lstm_bptt_delta #(
        .WIDTH(32), .FRAC(16), .NUM_LSTM(2), .T_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .i_push(i_push),
        .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
        .i_tc(i_tc), .i_cprev(i_cprev),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_ovf(o_ovf), .i_bwd_start(i_bwd_start),
        .i_dh(i_dh), .i_dh_valid(i_dh_valid), .o_dh_ready(o_dh_ready),
        .o_d_a(o_d_a), .o_d_i(o_d_i), .o_d_f(o_d_f),
        .o_d_o(o_d_o), .o_d_c(o_d_c),
        .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [W-1:0] tc);
        i_a     = {N{32'h8000}};
        i_i     = {N{32'h8000}};
        i_f     = {N{32'h8000}};
        i_o     = {N{32'h8000}};
        i_cprev = {N{32'h8000}};
        i_tc    = {N{tc}};
    endtask

    task automatic push(input logic [W-1:0] tc);
        set_rec(tc);
        i_push = 1'b1;
        tick();
        i_push = 1'b0;
    endtask

    task automatic start();
        i_bwd_start = 1'b1;
        tick();
        i_bwd_start = 1'b0;
    endtask

    // Waits for ready, hands over dh=1.0, returns latency and the outputs
    // seen on the o_valid cycle.
    task automatic do_step(
        output int lat,
        output logic [VW-1:0] da, output logic [VW-1:0] dc,
        output logic [VW-1:0] di, output logic [VW-1:0] df,
        output logic [VW-1:0] dox
    );
        int n = 0;
        while (!o_dh_ready && n < 20) begin
            tick();
            n++;
        end
        i_dh = {N{32'h10000}};
        i_dh_valid = 1'b1;
        tick();
        i_dh_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        da = o_d_a;
        dc = o_d_c;
        di = o_d_i;
        df = o_d_f;
        dox = o_d_o;
    endtask

    task automatic test_reset();
        total++;
        if (o_count !== 3'd0) begin
            bad++; $display("FAIL rst_count got=%0d exp=0", o_count);
        end
        total++;
        if ({o_empty, o_full, o_ovf} !== 3'b100) begin
            bad++;
            $display("FAIL rst_flags got=%b exp=100", {o_empty, o_full, o_ovf});
        end
        total++;
        if ({o_busy, o_valid, o_done, o_dh_ready} !== 4'b0) begin
            bad++;
            $display("FAIL rst_ctl got=%b exp=0000",
                     {o_busy, o_valid, o_done, o_dh_ready});
        end
        total++;
        if ((o_d_a | o_d_i | o_d_f | o_d_o | o_d_c) !== '0) begin
            bad++; $display("FAIL rst_deltas got=%h exp=0", o_d_c);
        end
    endtask

    task automatic test_single();
        int lat;
        logic [VW-1:0] da, dc, di, df, dox;
        push(32'h8000);
        total++;
        if (o_count !== 3'd1) begin
            bad++; $display("FAIL single_count got=%0d exp=1", o_count);
        end
        start();
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL single_latency got=%0d exp=3", lat);
        end
        total++;
        if (dox !== {N{32'h2000}}) begin
            bad++; $display("FAIL single_d_o got=%h exp=%h", dox, {N{32'h2000}});
        end
        total++;
        if (dc !== {N{32'h6000}}) begin
            bad++; $display("FAIL single_d_c got=%h exp=%h", dc, {N{32'h6000}});
        end
        total++;
        if (di !== {N{32'h0C00}}) begin
            bad++; $display("FAIL single_d_i got=%h exp=%h", di, {N{32'h0C00}});
        end
        total++;
        if (df !== {N{32'h0C00}}) begin
            bad++; $display("FAIL single_d_f got=%h exp=%h", df, {N{32'h0C00}});
        end
        total++;
        if (da !== {N{32'h2400}}) begin
            bad++; $display("FAIL single_d_a got=%h exp=%h", da, {N{32'h2400}});
        end
        tick();
        total++;
        if ({o_done, o_valid} !== 2'b10) begin
            bad++; $display("FAIL single_done got=%b exp=10", {o_done, o_valid});
        end
        tick();
        total++;
        if ({o_busy, o_done, o_count} !== 5'b0) begin
            bad++;
            $display("FAIL single_idle got=%b/%b/%0d exp=0/0/0",
                     o_busy, o_done, o_count);
        end
    endtask

    task automatic test_two_steps();
        int lat;
        logic [VW-1:0] da, dc, di, df, dox;
        push(32'h8000);
        push(32'h8000);
        start();
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (dc !== {N{32'h6000}}) begin
            bad++; $display("FAIL two_s1_d_c got=%h exp=%h", dc, {N{32'h6000}});
        end
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL two_s2_latency got=%0d exp=3", lat);
        end
        total++;
        if (dc !== {N{32'h9000}}) begin
            bad++; $display("FAIL two_s2_d_c got=%h exp=%h", dc, {N{32'h9000}});
        end
        total++;
        if ({di, df} !== {{N{32'h1200}}, {N{32'h1200}}}) begin
            bad++; $display("FAIL two_s2_d_i_f got=%h/%h exp=1200s", di, df);
        end
        total++;
        if (da !== {N{32'h3600}}) begin
            bad++; $display("FAIL two_s2_d_a got=%h exp=%h", da, {N{32'h3600}});
        end
        total++;
        if (dox !== {N{32'h2000}}) begin
            bad++; $display("FAIL two_s2_d_o got=%h exp=%h", dox, {N{32'h2000}});
        end
        tick();
        total++;
        if (o_done !== 1'b1) begin
            bad++; $display("FAIL two_done got=%b exp=1", o_done);
        end
        tick();
    endtask

    task automatic test_lifo_order();
        int lat;
        logic [VW-1:0] da, dc, di, df, dox;
        push(32'h4000);
        push(32'h8000);
        start();
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (dox !== {N{32'h2000}}) begin
            bad++; $display("FAIL lifo_first_d_o got=%h exp=%h", dox, {N{32'h2000}});
        end
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (dox !== {N{32'h1000}}) begin
            bad++; $display("FAIL lifo_second_d_o got=%h exp=%h", dox, {N{32'h1000}});
        end
        tick();
        total++;
        if (o_done !== 1'b1) begin
            bad++; $display("FAIL lifo_done got=%b exp=1", o_done);
        end
        tick();
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 4; n++)
            push(32'h8000);
        total++;
        if ({o_full, o_count, o_ovf} !== {1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL ovf_full got=%b/%0d/%b exp=1/4/0", o_full, o_count, o_ovf);
        end
        push(32'h8000);
        total++;
        if ({o_count, o_ovf} !== {3'd4, 1'b1}) begin
            bad++; $display("FAIL ovf_flag got=%0d/%b exp=4/1", o_count, o_ovf);
        end
        start();
        total++;
        if (o_dh_ready !== 1'b1) begin
            bad++; $display("FAIL ovf_ready got=%b exp=1", o_dh_ready);
        end
        push(32'h8000);
        total++;
        if (o_count !== 3'd4) begin
            bad++; $display("FAIL wait_push_count got=%0d exp=4", o_count);
        end
    endtask

    task automatic test_reset_mid();
        i_dh = {N{32'h10000}};
        i_dh_valid = 1'b1;
        tick();
        i_dh_valid = 1'b0;
        total++;
        if ({o_busy, o_count} !== {1'b1, 3'd3}) begin
            bad++; $display("FAIL mid_cell got=%b/%0d exp=1/3", o_busy, o_count);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({o_busy, o_valid, o_done, o_dh_ready, o_ovf, o_count} !== 8'b0) begin
            bad++;
            $display("FAIL mid_reset_ctl got=%b/%0d exp=0/0",
                     {o_busy, o_valid, o_done, o_dh_ready, o_ovf}, o_count);
        end
        total++;
        if ((o_d_a | o_d_i | o_d_f | o_d_o | o_d_c) !== '0) begin
            bad++; $display("FAIL mid_reset_deltas got=%h exp=0", o_d_c);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL mid_idle got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_empty_start();
        start();
        total++;
        if ({o_done, o_valid} !== 2'b10) begin
            bad++; $display("FAIL empty_done got=%b exp=10", {o_done, o_valid});
        end
        tick();
        total++;
        if ({o_busy, o_done, o_valid} !== 3'b0) begin
            bad++;
            $display("FAIL empty_idle got=%b exp=000", {o_busy, o_done, o_valid});
        end
    endtask

    task automatic test_priority();
        int lat;
        logic [VW-1:0] da, dc, di, df, dox;
        push(32'h8000);
        set_rec(32'h8000);
        i_push = 1'b1;
        i_bwd_start = 1'b1;
        tick();
        i_push = 1'b0;
        i_bwd_start = 1'b0;
        total++;
        if ({o_count, o_ovf, o_dh_ready} !== {3'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL prio_count got=%0d/%b/%b exp=1/0/1",
                     o_count, o_ovf, o_dh_ready);
        end
        do_step(lat, da, dc, di, df, dox);
        total++;
        if (dc !== {N{32'h6000}}) begin
            bad++; $display("FAIL prio_d_c got=%h exp=%h", dc, {N{32'h6000}});
        end
        tick();
        total++;
        if ({o_done, o_count} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL prio_done got=%b/%0d exp=1/0", o_done, o_count);
        end
        tick();
    endtask

    initial begin
        set_rec(32'h8000);
        i_dh = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        tick();
        test_single();
        test_two_steps();
        test_lifo_order();
        test_overflow();
        test_reset_mid();
        test_empty_start();
        test_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
